// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/update sequencer that drives the PC register input,
// arbitrates jr > j > br redirects and stops fetching on halt.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pc_in               current PC register value
//   imem_ready          instruction memory accepted the current fetch
//   stall               pipeline hold, gates FETCH -> UPDATE only
//   br_req/br_target    branch redirect
//   j_req/j_target      jump redirect
//   jr_req/jr_target    register-jump redirect
//   halt                stop-fetch request
//   pc_next, pc_load    PC register input value and load strobe
//   fetch_req           fetch in progress at pc_in
//   halted              sequencer stopped until reset
//   align_err           winning target had nonzero bits [1:0]
//   fetch_count         completed PC updates (wraps)
//
// Optional: define PC_SEQ_TRACE_EN to print a timestamped trace of
// updates, alignment errors, HALTED entry and resets.

module pc_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_in,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        br_req,
    input  logic [31:0] br_target,
    input  logic        j_req,
    input  logic [31:0] j_target,
    input  logic        jr_req,
    input  logic [31:0] jr_target,
    input  logic        halt,
    output logic [31:0] pc_next,
    output logic        pc_load,
    output logic        fetch_req,
    output logic        halted,
    output logic        align_err,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        UPDATE,
        HALTED
    } state_t;

    // Encoding doubles as priority: a larger value wins.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_BR   = 2'd1,
        SRC_J    = 2'd2,
        SRC_JR   = 2'd3
    } src_t;

    state_t      state;
    state_t      state_n;

    src_t        pend_src;
    logic [31:0] pend_tgt;
    logic        halt_pending;

    src_t        live_src;
    logic [31:0] live_tgt;
    src_t        win_src;
    logic [31:0] win_tgt;
    logic        win_misaligned;

    // Highest-priority live redirect this cycle.
    always_comb begin
        live_src = SRC_NONE;
        live_tgt = '0;
        if (jr_req) begin
            live_src = SRC_JR;
            live_tgt = jr_target;
        end else if (j_req) begin
            live_src = SRC_J;
            live_tgt = j_target;
        end else if (br_req) begin
            live_src = SRC_BR;
            live_tgt = br_target;
        end
    end

    // On an equal-priority tie the older pending request is kept,
    // matching the drop rule applied while latching in FETCH.
    always_comb begin
        win_src = live_src;
        win_tgt = live_tgt;
        if ((pend_src != SRC_NONE) && (pend_src >= live_src)) begin
            win_src = pend_src;
            win_tgt = pend_tgt;
        end
        win_misaligned = (win_src != SRC_NONE) && (win_tgt[1:0] != 2'b00);
    end

    // Next state and Moore/Mealy outputs.
    always_comb begin
        state_n   = state;
        pc_next   = pc_in;
        pc_load   = 1'b0;
        fetch_req = 1'b0;
        halted    = 1'b0;
        align_err = 1'b0;
        unique case (state)
            IDLE: begin
                state_n = FETCH;
            end
            FETCH: begin
                fetch_req = 1'b1;
                if (imem_ready && !stall) begin
                    state_n = UPDATE;
                end
            end
            UPDATE: begin
                pc_load = 1'b1;
                if (win_src != SRC_NONE) begin
                    pc_next = {win_tgt[31:2], 2'b00};
                end else begin
                    pc_next = pc_in + 32'd4;
                end
                align_err = win_misaligned;
                // A halt seen in this very cycle counts as pending too.
                if (halt_pending || halt) begin
                    state_n = HALTED;
                end else begin
                    state_n = FETCH;
                end
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pend_src     <= SRC_NONE;
            pend_tgt     <= '0;
            halt_pending <= 1'b0;
            fetch_count  <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                FETCH: begin
                    if (live_src > pend_src) begin
                        pend_src <= live_src;
                        pend_tgt <= live_tgt;
                    end
                    if (halt) begin
                        halt_pending <= 1'b1;
                    end
                end
                UPDATE: begin
                    pend_src    <= SRC_NONE;
                    pend_tgt    <= '0;
                    fetch_count <= fetch_count + 16'd1;
                    if (halt) begin
                        halt_pending <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PC_SEQ_TRACE_EN
    function automatic string src_name(input src_t s);
        case (s)
            SRC_BR:  return "br";
            SRC_J:   return "j";
            SRC_JR:  return "jr";
            default: return "seq";
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst_n) begin
            if (state == UPDATE) begin
                $display("%0t pc_sequencer: update pc_next=%08h src=%s",
                         $time, pc_next, src_name(win_src));
            end
            if (align_err) begin
                $display("%0t pc_sequencer: align_err target=%08h",
                         $time, win_tgt);
            end
            if ((state != HALTED) && (state_n == HALTED)) begin
                $display("%0t pc_sequencer: entering HALTED", $time);
            end
        end
    end

    always @(negedge rst_n) begin
        $display("%0t pc_sequencer: reset", $time);
    end
`else
    // Trace disabled: no simulation output.
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors for pc_sequencer with a PC register
// harness; inputs change 2 ns after posedge, outputs sampled at negedge.

module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_in;
    logic        imem_ready;
    logic        stall;
    logic        br_req;
    logic [31:0] br_target;
    logic        j_req;
    logic [31:0] j_target;
    logic        jr_req;
    logic [31:0] jr_target;
    logic        halt;
    logic [31:0] pc_next;
    logic        pc_load;
    logic        fetch_req;
    logic        halted;
    logic        align_err;
    logic [15:0] fetch_count;

    logic [31:0] pc_reg;
    logic        pc_ovr;
    logic [31:0] pc_ovr_val;

    int checks;
    int fails;

    pc_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_in       (pc_in),
        .imem_ready  (imem_ready),
        .stall       (stall),
        .br_req      (br_req),
        .br_target   (br_target),
        .j_req       (j_req),
        .j_target    (j_target),
        .jr_req      (jr_req),
        .jr_target   (jr_target),
        .halt        (halt),
        .pc_next     (pc_next),
        .pc_load     (pc_load),
        .fetch_req   (fetch_req),
        .halted      (halted),
        .align_err   (align_err),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register the sequencer drives; resets to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg <= '0;
        end else if (pc_load) begin
            pc_reg <= pc_next;
        end
    end

    assign pc_in = pc_ovr ? pc_ovr_val : pc_reg;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        checks     = 0;
        fails      = 0;
        rst_n      = 1'b0;
        imem_ready = 1'b1;
        stall      = 1'b0;
        br_req     = 1'b0;
        br_target  = '0;
        j_req      = 1'b0;
        j_target   = '0;
        jr_req     = 1'b0;
        jr_target  = '0;
        halt       = 1'b0;
        pc_ovr     = 1'b0;
        pc_ovr_val = '0;

        // Reset state
        #12;
        check("rst_pc_load", pc_load, 0);
        check("rst_fetch_req", fetch_req, 0);
        check("rst_halted", halted, 0);
        check("rst_align_err", align_err, 0);
        check("rst_count", fetch_count, 0);
        check("rst_pc_next", pc_next, 0);

        // Sequential fetch: loads on cycles 3, 5, 7
        cyc();
        rst_n = 1'b1;
        smp();
        check("idle_fetch_req", fetch_req, 0);
        check("idle_pc_load", pc_load, 0);
        for (int k = 2; k <= 7; k++) begin
            cyc();
            smp();
            check($sformatf("seq_c%0d_load", k), pc_load, (k % 2));
            check($sformatf("seq_c%0d_freq", k), fetch_req,
                  ((k % 2) == 0) ? 1 : 0);
            if ((k % 2) == 1) begin
                check($sformatf("seq_c%0d_pc", k), pc_next, 4 * ((k - 1) / 2));
            end
        end
        cyc();
        imem_ready = 1'b0;
        smp();
        check("seq_count", fetch_count, 3);
        check("seq_fetch_hold", fetch_req, 1);

        // br then jr while fetching: jr wins, then sequential
        cyc();
        br_req    = 1'b1;
        br_target = 32'h40;
        smp();
        check("fetch_pc_next_passthru", pc_next, 32'hC);
        check("fetch_no_load", pc_load, 0);
        cyc();
        br_req    = 1'b0;
        jr_req    = 1'b1;
        jr_target = 32'h100;
        cyc();
        jr_req     = 1'b0;
        imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0;
        smp();
        check("prio_load", pc_load, 1);
        check("prio_jr_wins", pc_next, 32'h100);
        check("prio_align", align_err, 0);
        cyc();
        imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0;
        smp();
        check("after_redir_seq", pc_next, 32'h104);

        // Misaligned jump arriving in UPDATE
        cyc();
        imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0;
        j_req      = 1'b1;
        j_target   = 32'h203;
        smp();
        check("misal_pc", pc_next, 32'h200);
        check("misal_err", align_err, 1);
        cyc();
        j_req = 1'b0;
        smp();
        check("misal_err_clear", align_err, 0);
        check("misal_no_load", pc_load, 0);

        // Stall for 5 cycles with memory ready
        cyc();
        imem_ready = 1'b1;
        stall      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc();
            smp();
            check($sformatf("stall%0d_freq", i), fetch_req, 1);
            check($sformatf("stall%0d_load", i), pc_load, 0);
        end
        cyc();
        stall = 1'b0;
        smp();
        check("stall_drop_freq", fetch_req, 1);
        check("stall_drop_load", pc_load, 0);
        cyc();
        stall      = 1'b1;
        imem_ready = 1'b0;
        smp();
        check("stall_upd_load", pc_load, 1);
        check("stall_upd_pc", pc_next, 32'h204);
        cyc();
        stall = 1'b0;
        smp();
        check("stall_back_fetch", fetch_req, 1);

        // Lower-priority br dropped while j pending
        cyc();
        j_req    = 1'b1;
        j_target = 32'h300;
        cyc();
        j_req     = 1'b0;
        br_req    = 1'b1;
        br_target = 32'h500;
        cyc();
        br_req     = 1'b0;
        imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0;
        smp();
        check("drop_low_prio", pc_next, 32'h300);

        // Live j in UPDATE beats pending br; slot then clears
        cyc();
        br_req    = 1'b1;
        br_target = 32'h600;
        cyc();
        br_req     = 1'b0;
        imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0;
        j_req      = 1'b1;
        j_target   = 32'h700;
        smp();
        check("live_beats_pend", pc_next, 32'h700);
        cyc();
        j_req      = 1'b0;
        imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0;
        smp();
        check("pend_cleared", pc_next, 32'h704);

        // PC and fetch_count wrap
        cyc();
        pc_ovr     = 1'b1;
        pc_ovr_val = 32'hFFFF_FFFC;
        force dut.fetch_count = 16'hFFFF;
        cyc();
        release dut.fetch_count;
        imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0;
        smp();
        check("wrap_pc", pc_next, 32'h0);
        check("wrap_load", pc_load, 1);
        cyc();
        pc_ovr = 1'b0;
        smp();
        check("wrap_count", fetch_count, 16'h0000);

        // Halt in FETCH: finish the update, then stop
        cyc();
        pc_ovr     = 1'b1;
        pc_ovr_val = 32'h20;
        halt       = 1'b1;
        cyc();
        halt       = 1'b0;
        imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0;
        smp();
        check("halt_upd_load", pc_load, 1);
        check("halt_upd_pc", pc_next, 32'h24);
        check("halt_upd_not_halted", halted, 0);
        cyc();
        pc_ovr     = 1'b0;
        imem_ready = 1'b1;
        smp();
        check("halted_set", halted, 1);
        check("halted_no_fetch", fetch_req, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            smp();
            check($sformatf("halted%0d_no_load", i), pc_load, 0);
            check($sformatf("halted%0d_hold", i), halted, 1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_halted", halted, 0);
        check("async_rst_count", fetch_count, 0);

        // Halt during IDLE ignored; first fetch from 0; reset mid-UPDATE
        cyc();
        rst_n = 1'b1;
        halt  = 1'b1;
        cyc();
        halt = 1'b0;
        smp();
        check("restart_fetch", fetch_req, 1);
        cyc();
        smp();
        check("restart_pc", pc_next, 32'h4);
        cyc();
        smp();
        check("idle_halt_ignored", halted, 0);
        check("idle_halt_fetch", fetch_req, 1);
        cyc();
        check("mid_upd_load", pc_load, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_no_load", pc_load, 0);
        check("abort_no_fetch", fetch_req, 0);
        check("abort_pc_next", pc_next, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
